imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Handshake and memory-write bundle for imem_loader.
//   master : control/byte source (start, word_count, abort, byte_valid, byte_data)
//            and observer of loader status and memory-write outputs
//   slave  : the loader itself
interface imem_loader_if;
    logic        start;
    logic [15:0] word_count;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, word_count, abort, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
    );

    modport slave (
        input  start, word_count, abort, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata, core_hold, busy, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a byte stream (MSB of each word first),
// packs it into 32-bit words and writes them to instruction memory starting
// at BASE_ADDR, holding the core in reset while loading.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : imem_loader_if.slave (start/word_count/abort control, byte stream
//           in, mem_we/mem_addr/mem_wdata out, core_hold/busy/done/err status)
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [15:0] remaining;
    logic        we_r;
    logic        ready_r;
    logic        hold_r;
    logic        done_r;
    logic        err_r;
    logic [31:0] addr_r;
    logic [31:0] data_r;   // doubles as the word assembler while in RECV

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            byte_idx  <= 2'd0;
            remaining <= 16'd0;
            we_r      <= 1'b0;
            ready_r   <= 1'b0;
            hold_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            addr_r    <= 32'd0;
            data_r    <= 32'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_r <= 1'b0;
                        if (bus.word_count != 16'd0) begin
                            remaining <= bus.word_count;
                            addr_r    <= BASE_ADDR;
                            byte_idx  <= 2'd0;
                            ready_r   <= 1'b1;
                            hold_r    <= 1'b1;
                            state     <= RECV;
                        end else begin
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RECV: begin
                    if (bus.abort) begin
                        // partial word is simply dropped
                        err_r    <= 1'b1;
                        ready_r  <= 1'b0;
                        hold_r   <= 1'b0;
                        byte_idx <= 2'd0;
                        state    <= IDLE;
                    end else if (bus.byte_valid) begin
                        data_r   <= {data_r[23:0], bus.byte_data};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            ready_r <= 1'b0;
                            we_r    <= 1'b1;
                            state   <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    we_r <= 1'b0;
                    if (bus.abort) begin
                        err_r    <= 1'b1;
                        hold_r   <= 1'b0;
                        byte_idx <= 2'd0;
                        state    <= IDLE;
                    end else begin
                        addr_r    <= addr_r + 32'd4;
                        remaining <= remaining - 16'd1;
                        byte_idx  <= 2'd0;
                        if (remaining == 16'd1) begin
                            hold_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            ready_r <= 1'b1;
                            state   <= RECV;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // abort must kill a write strobe already presented in the WRITE cycle
    assign bus.mem_we     = we_r & ~bus.abort;
    assign bus.byte_ready = ready_r;
    assign bus.mem_addr   = addr_r;
    assign bus.mem_wdata  = data_r;
    assign bus.core_hold  = hold_r;
    assign bus.busy       = hold_r;
    assign bus.done       = done_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if if0 ();
    imem_loader_if if1 ();

    // second instance sees identical stimulus, only the base differs
    assign if1.start      = if0.start;
    assign if1.word_count = if0.word_count;
    assign if1.abort      = if0.abort;
    assign if1.byte_valid = if0.byte_valid;
    assign if1.byte_data  = if0.byte_data;

    imem_loader #(.BASE_ADDR(BASE0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    imem_loader #(.BASE_ADDR(BASE1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int exp_done0 = 0;
    int exp_done1 = 0;
    logic [63:0] wq0[$];
    logic [63:0] wq1[$];
    int acc_q[$];
    logic [7:0] fixed_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_flags0"}, 64'({if0.byte_ready, if0.mem_we, if0.core_hold, if0.busy, if0.done, if0.err}), 64'd0);
        chk({tag, "_bus0"}, {if0.mem_addr, if0.mem_wdata}, 64'd0);
        chk({tag, "_flags1"}, 64'({if1.byte_ready, if1.mem_we, if1.core_hold, if1.busy, if1.done, if1.err}), 64'd0);
        chk({tag, "_bus1"}, {if1.mem_addr, if1.mem_wdata}, 64'd0);
    endtask

    // monitor: pops the scoreboard whenever a DUT presents a write or done
    initial begin
        logic [63:0] e;
        int a;
        forever begin
            @(negedge clk);
            if (if0.mem_we) begin
                chk("we0_ready_low", 64'(if0.byte_ready), 64'd0);
                chk("we0_hold", 64'(if0.core_hold), 64'd1);
                if (wq0.size() == 0) chk("we0_unexpected", 64'd1, 64'd0);
                else begin
                    e = wq0.pop_front();
                    chk("wr0_addr", 64'(if0.mem_addr), 64'(e[63:32]));
                    chk("wr0_data", 64'(if0.mem_wdata), 64'(e[31:0]));
                end
                if (acc_q.size() > 0) begin
                    a = acc_q.pop_front();
                    chk("wr_latency", 64'(cyc), 64'(a + 1));
                end
            end
            if (if1.mem_we) begin
                if (wq1.size() == 0) chk("we1_unexpected", 64'd1, 64'd0);
                else begin
                    e = wq1.pop_front();
                    chk("wr1_addr", 64'(if1.mem_addr), 64'(e[63:32]));
                    chk("wr1_data", 64'(if1.mem_wdata), 64'(e[31:0]));
                end
            end
            if (if0.done) begin
                chk("done0_expected", 64'(exp_done0 > 0), 64'd1);
                chk("done0_hold", 64'({if0.core_hold, if0.busy}), 64'd0);
                if (exp_done0 > 0) exp_done0--;
            end
            if (if1.done) begin
                chk("done1_expected", 64'(exp_done1 > 0), 64'd1);
                if (exp_done1 > 0) exp_done1--;
            end
        end
    end

    // kill: 0 none, 1 abort after 'after' transferred bytes, 2 reset after 'after' bytes
    // gap : 0 back-to-back, 1 random byte_valid, 2 byte_valid toggling 1/0
    task automatic run_load(input int n, input int gap, input int kill, input int after);
        logic [7:0] bq[$];
        logic [31:0] w;
        int nw, sent, cycles;
        logic bv, xf;
        if (n > 0 && fixed_bytes.size() == n * 4) begin
            bq = fixed_bytes;
            fixed_bytes.delete();
        end else begin
            for (int i = 0; i < n * 4; i++) bq.push_back(8'($urandom));
        end
        // reference: word i = bytes 4i..4i+3 big-endian at base + 4i; an abort
        // landing right after a 4th byte cancels that word's write cycle
        nw = n;
        if (kill == 1) nw = (after % 4 == 0) ? after / 4 - 1 : after / 4;
        else if (kill == 2) nw = after / 4;
        for (int i = 0; i < nw; i++) begin
            w = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
            wq0.push_back({BASE0 + 32'(4 * i), w});
            wq1.push_back({BASE1 + 32'(4 * i), w});
        end
        if (kill == 0) begin
            exp_done0++;
            exp_done1++;
        end

        if0.start = 1'b1;
        if0.word_count = 16'(n);
        @(posedge clk); #1;
        if0.start = 1'b0;
        if0.word_count = 16'($urandom);
        chk("err_clr_on_start", 64'(if0.err), 64'd0);

        sent = 0;
        cycles = 0;
        while (sent < n * 4 && !(kill != 0 && sent == after)) begin
            case (gap)
                0: bv = 1'b1;
                1: bv = 1'($urandom % 2);
                default: bv = (cycles % 2 == 0);
            endcase
            if0.byte_valid = bv;
            if0.byte_data = bq[sent];
            if0.start = ($urandom % 4 == 0);
            @(negedge clk);
            xf = bv && if0.byte_ready;
            if (xf && sent % 4 == 3) acc_q.push_back(cyc);
            @(posedge clk); #1;
            if (xf) sent++;
            cycles++;
            if (cycles > 2000) begin
                chk("recv_timeout", 64'(cycles), 64'd0);
                break;
            end
        end
        if0.byte_valid = 1'b0;
        if0.start = 1'b0;

        if (kill == 1) begin
            if0.abort = 1'b1;
            @(posedge clk); #1;
            if0.abort = 1'b0;
        end else if (kill == 2) begin
            reset = 1'b0;
            @(posedge clk); #1;
            chk_zero("reset_in_write");
            reset = 1'b1;
        end

        repeat (6) @(posedge clk);
        #1;
        chk("err", 64'(if0.err), 64'(kill == 1));
        chk("idle_flags", 64'({if0.byte_ready, if0.mem_we, if0.core_hold, if0.busy, if0.done}), 64'd0);
        chk("writes_left0", 64'(wq0.size()), 64'd0);
        chk("writes_left1", 64'(wq1.size()), 64'd0);
        chk("dones_left", 64'(exp_done0 + exp_done1), 64'd0);
        wq0.delete();
        wq1.delete();
        acc_q.delete();
        exp_done0 = 0;
        exp_done1 = 0;
    endtask

    initial begin
        int n, g, k, a;
        if0.start = 1'b0;
        if0.word_count = 16'd0;
        if0.abort = 1'b0;
        if0.byte_valid = 1'b0;
        if0.byte_data = 8'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_state");
        reset = 1'b1;
        @(posedge clk); #1;

        // two words back-to-back, both bases (second base wraps to 0)
        fixed_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_load(2, 0, 0, 0);
        // single word with byte_valid toggling
        run_load(1, 2, 0, 0);
        // abort after two bytes of the second word, then a clean load
        run_load(3, 1, 1, 6);
        run_load(2, 1, 0, 0);
        // abort landing in a WRITE cycle
        run_load(2, 0, 1, 4);
        // reset during WRITE, then a zero-length load
        run_load(1, 0, 2, 4);
        run_load(0, 0, 0, 0);

        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, 5);
            g = $urandom_range(0, 2);
            k = (n > 0 && $urandom % 3 == 0) ? 1 : 0;
            a = (n > 0) ? $urandom_range(1, n * 4) : 0;
            run_load(n, g, k, a);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
